// File: rtl/vga_pixel_reader.sv
// Pulls RGB565 pixels from a show-ahead FIFO and drives 800x600@60 VGA timing.
// Popping starts only after the per-frame flush/restart handshake at line 600.
module vga_pixel_reader #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] q,
  input  logic        rdempty,
  output logic        rdreq,
  output logic        fifo_aclr,
  output logic        pixreq,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        underrun
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] PIXREQ_H  = 11'd8;
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS_END = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_START  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  typedef enum logic [1:0] {INIT, ACTIVE, UNDERRUN} state_t;

  state_t      state;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        visible;
  logic        flush_point;
  logic        restart_point;

  assign visible       = (hcount < H_VIS_END) && (vcount < V_VIS_END);
  assign flush_point   = (hcount == 11'd0) && (vcount == V_VIS_END);
  assign restart_point = (hcount == PIXREQ_H) && (vcount == V_VIS_END);

  // Reset forces state to INIT, so rdreq also drops asynchronously.
  assign rdreq = visible && (state == ACTIVE) && !rdempty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      state       <= INIT;
      fifo_aclr   <= 1'b0;
      pixreq      <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b0;
      vga_vs      <= 1'b0;
      vga_blank_n <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 11'd1;
      end

      vga_hs      <= (hcount >= HS_START) && (hcount <= HS_END);
      vga_vs      <= (vcount >= VS_START) && (vcount <= VS_END);
      vga_blank_n <= visible;
      fifo_aclr   <= flush_point;
      pixreq      <= restart_point;

      // Replicate the top bits so full-scale 565 maps to 8'hFF.
      if (rdreq) begin
        vga_r <= {q[15:11], q[15:13]};
        vga_g <= {q[10:5], q[10:9]};
        vga_b <= {q[4:0], q[4:2]};
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end

      // The restart point lies in blanking, so it never collides with an underrun.
      if (restart_point) begin
        state <= ACTIVE;
      end else if (state == ACTIVE && visible && rdempty) begin
        state    <= UNDERRUN;
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_reader.sv
// Directed bench for vga_pixel_reader on a shrunken 25x11 raster with a queue-based FIFO model.
// A per-cycle reference model checks every output; directed steps add hand-computed checks.
module tb_vga_pixel_reader;

  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int PIX_PER_FRAME = HV * VV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] q = 16'h0;
  logic        rdempty = 1'b1;
  logic        rdreq, fifo_aclr, pixreq;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, underrun;

  always #5 clk = ~clk;

  vga_pixel_reader #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .q(q), .rdempty(rdempty), .rdreq(rdreq),
    .fifo_aclr(fifo_aclr), .pixreq(pixreq),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .underrun(underrun)
  );

  int          checks = 0;
  int          errors = 0;
  int          exp_h = 0, exp_v = 0;
  bit          exp_active = 1'b0, exp_underrun = 1'b0;
  logic [15:0] fifo[$];
  bit          auto_fill = 1'b0;
  logic [15:0] fill_seq = 16'h1357;
  int          pop_count = 0;
  int          cyc = 0;
  int          aclr_cyc = -1, pixreq_cyc = -1;
  int          hs_high = 0, vs_high = 0, blank_high = 0;
  int          pops_snap;

  function automatic logic [23:0] expand(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic update_fifo_inputs();
    if (auto_fill)
      while (fifo.size() < 4) begin
        fifo.push_back(fill_seq);
        fill_seq = fill_seq + 16'h2F51;
      end
    rdempty = (fifo.size() == 0);
    q = rdempty ? 16'h0 : fifo[0];
  endtask

  task automatic model_reset();
    exp_h = 0;
    exp_v = 0;
    exp_active = 1'b0;
    exp_underrun = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdreq"}, 32'(rdreq), 32'd0);
    check({tag, "_aclr"}, 32'(fifo_aclr), 32'd0);
    check({tag, "_pixreq"}, 32'(pixreq), 32'd0);
    check({tag, "_colour"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    check({tag, "_hs"}, 32'(vga_hs), 32'd0);
    check({tag, "_vs"}, 32'(vga_vs), 32'd0);
    check({tag, "_blank_n"}, 32'(vga_blank_n), 32'd0);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  // One pixel clock: entered and left at a falling edge, where all outputs are checked.
  task automatic applyStimulus();
    bit          will_pop, empty_before, e_hs, e_vs, e_blank, e_aclr, e_pixreq, e_rd;
    logic [15:0] popped;
    int          ph, pv;
    will_pop     = rdreq;
    empty_before = rdempty;
    popped       = q;
    ph = exp_h;
    pv = exp_v;
    @(posedge clk);
    #1;
    if (will_pop) begin
      void'(fifo.pop_front());
      pop_count++;
    end
    update_fifo_inputs();
    if (ph == 8 && pv == VV) exp_active = 1'b1;
    else if (exp_active && ph < HV && pv < VV && empty_before) begin
      exp_active = 1'b0;
      exp_underrun = 1'b1;
    end
    if (exp_h == HT - 1) begin
      exp_h = 0;
      exp_v = (exp_v == VT - 1) ? 0 : exp_v + 1;
    end else exp_h = exp_h + 1;
    @(negedge clk);
    cyc++;
    e_hs     = (ph >= HV + HF) && (ph < HV + HF + HS);
    e_vs     = (pv >= VV + VF) && (pv < VV + VF + VS);
    e_blank  = (ph < HV) && (pv < VV);
    e_aclr   = (ph == 0) && (pv == VV);
    e_pixreq = (ph == 8) && (pv == VV);
    e_rd     = (exp_h < HV) && (exp_v < VV) && exp_active && !rdempty;
    check("colour", 32'({vga_r, vga_g, vga_b}), will_pop ? 32'(expand(popped)) : 32'd0);
    check("hs", 32'(vga_hs), 32'(e_hs));
    check("vs", 32'(vga_vs), 32'(e_vs));
    check("blank_n", 32'(vga_blank_n), 32'(e_blank));
    check("fifo_aclr", 32'(fifo_aclr), 32'(e_aclr));
    check("pixreq", 32'(pixreq), 32'(e_pixreq));
    check("underrun", 32'(underrun), 32'(exp_underrun));
    check("rdreq", 32'(rdreq), 32'(e_rd));
    if (vga_hs) hs_high++;
    if (vga_vs) vs_high++;
    if (vga_blank_n) blank_high++;
    if (fifo_aclr && aclr_cyc < 0) aclr_cyc = cyc;
    if (pixreq && pixreq_cyc < 0) pixreq_cyc = cyc;
  endtask

  task automatic checkOutput(input string tag, input logic [23:0] rgb);
    check(tag, 32'({vga_r, vga_g, vga_b}), 32'(rgb));
  endtask

  initial begin
    // Startup with a FIFO that never runs dry: frame 0 must not pop.
    auto_fill = 1'b1;
    update_fifo_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    model_reset();
    repeat (FRAME) applyStimulus();
    check("frame0_pops", 32'(pop_count), 32'd0);
    check("aclr_to_pixreq", 32'(pixreq_cyc - aclr_cyc), 32'd8);

    hs_high = 0;
    vs_high = 0;
    blank_high = 0;
    repeat (FRAME - 1) applyStimulus();
    // Load directed colours just before frame 2, while still in blanking.
    auto_fill = 1'b0;
    fifo.delete();
    fifo.push_back(16'hF800);
    fifo.push_back(16'h07E0);
    fifo.push_back(16'h001F);
    fifo.push_back(16'h0000);
    fifo.push_back(16'h8410);
    fifo.push_back(16'hFFFF);
    fifo.push_back(16'h1234);
    fifo.push_back(16'hABCD);
    fifo.push_back(16'h0841);
    fifo.push_back(16'h7BEF);
    update_fifo_inputs();
    #1;
    applyStimulus();
    check("frame1_pops", 32'(pop_count), 32'(PIX_PER_FRAME));
    check("frame1_hs_high", 32'(hs_high), 32'(VT * HS));
    check("frame1_vs_high", 32'(vs_high), 32'(VS * HT));
    check("frame1_blank_high", 32'(blank_high), 32'(PIX_PER_FRAME));
    check("frame1_underrun", 32'(underrun), 32'd0);

    applyStimulus();
    checkOutput("red", 24'hFF0000);
    applyStimulus();
    checkOutput("green", 24'h00FF00);
    applyStimulus();
    checkOutput("blue", 24'h0000FF);
    applyStimulus();
    checkOutput("black", 24'h000000);
    repeat (5) applyStimulus();
    applyStimulus();
    checkOutput("last_pixel", 24'h7B7D7B);
    applyStimulus();
    check("underrun_set", 32'(underrun), 32'd1);
    checkOutput("underrun_pixel", 24'h000000);

    // Data reappears mid-frame; nothing may pop until the next restart.
    repeat (2) applyStimulus();
    auto_fill = 1'b1;
    update_fifo_inputs();
    #1;
    repeat (FRAME - 13) applyStimulus();
    check("frame2_pops", 32'(pop_count), 32'(PIX_PER_FRAME + 10));

    repeat (3 * HT + 5) applyStimulus();
    check("frame3_pops", 32'(pop_count), 32'(PIX_PER_FRAME + 10 + 3 * HV + 5));
    check("frame3_underrun_sticky", 32'(underrun), 32'd1);
    check("frame3_rdreq", 32'(rdreq), 32'd1);

    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midreset_hold");
    reset = 1'b0;
    pops_snap = pop_count;
    repeat (FRAME) applyStimulus();
    check("post_reset_frame0_pops", 32'(pop_count - pops_snap), 32'd0);
    repeat (2 * HT) applyStimulus();
    check("post_reset_frame1_pops", 32'(pop_count - pops_snap), 32'(2 * HV));
    check("post_reset_underrun", 32'(underrun), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_pixel_reader.md
VGA_PIXEL_READER -- requirements
Module: vga_pixel_reader

Interface
REQ-001 SHALL have port clk, input, 1 bit: 40 MHz pixel clock; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port q, input, 16 bits: pixel FIFO read data, RGB565, show-ahead (valid whenever rdempty=0).
REQ-004 SHALL have port rdempty, input, 1 bit: pixel FIFO empty.
REQ-005 SHALL have port rdreq, output, 1 bit: FIFO pop; combinational; consumes current q at the clock edge.
REQ-006 SHALL have port fifo_aclr, output, 1 bit: registered one-cycle FIFO flush pulse.
REQ-007 SHALL have port pixreq, output, 1 bit: registered one-cycle pulse requesting the SDRAM reader to restart at the frame base.
REQ-008 SHALL have ports vga_r, vga_g, vga_b, outputs, 8 bits each: registered colour.
REQ-009 SHALL have ports vga_hs, vga_vs, vga_blank_n, outputs, 1 bit each: registered sync (positive polarity) and blank (active-low).
REQ-010 SHALL have port underrun, output, 1 bit: sticky underrun flag.

Function
REQ-011 SHALL keep hcount 0..1055 (wrap to 0) and vcount 0..627 (advance when hcount wraps; wrap to 0): 800x600@60, H 800/40/128/88, V 600/1/4/23.
REQ-012 SHALL define visible = hcount<800 and vcount<600.
REQ-013 SHALL register, one cycle after each counter state: vga_hs = hcount in 840..967; vga_vs = vcount in 601..604; vga_blank_n = visible.
REQ-014 SHALL implement states INIT, ACTIVE and UNDERRUN.
REQ-015 SHALL drive rdreq = visible and state==ACTIVE and rdempty=0, and no other way.
REQ-016 SHALL, one cycle after a popped pixel, output vga_r={q[15:11],q[15:13]}, vga_g={q[10:5],q[10:9]} and vga_b={q[4:0],q[4:2]} for that pixel.
REQ-017 SHALL output colour 0 for every non-popped pixel: blanking, INIT or UNDERRUN.
REQ-018 SHALL assert fifo_aclr in the cycle after the counters equal (h=0, v=600).
REQ-019 SHALL assert pixreq in the cycle after the counters equal (h=8, v=600); exactly one pulse per frame.
REQ-020 SHALL transition INIT->ACTIVE and UNDERRUN->ACTIVE on the counter state (8,600); ACTIVE remains ACTIVE there.
REQ-021 SHALL transition ACTIVE->UNDERRUN when visible=1 and rdempty=1, and set underrun=1 on that cycle; that pixel and the rest of the frame are black and no pops occur.
REQ-022 SHALL clear underrun only on reset; repeated underruns leave it at 1.
REQ-023 SHALL ignore rdempty outside visible pixels, without a state change.
REQ-024 SHALL pop exactly 480000 pixels per frame in ACTIVE with no underrun, matching one SDRAM frame buffer.

Reset
REQ-025 SHALL, while reset=1, immediately force: hcount=0, vcount=0, state=INIT, and all outputs 0 (rdreq, fifo_aclr, pixreq, colour, vga_hs, vga_vs, vga_blank_n, underrun).
REQ-026 SHALL, on reset release at any point in a frame, count from (0,0) and pop nothing until the first (8,600) pixreq.

Verification
REQ-027 SHALL cover timing: free-run 2 frames -> vga_hs period 1056 with high width 128; vga_vs period 663168 with high width 4224; vga_blank_n high 800 cycles per line on 600 lines.
REQ-028 SHALL cover startup: release reset with the FIFO model full -> rdreq=0 through frame 0; fifo_aclr pulses, pixreq pulses 8 cycles later; frame 1 pops 480000 pixels; underrun=0.
REQ-029 SHALL cover colour: FIFO supplies 16'hF800, 16'h07E0, 16'h001F, 16'h0000 -> (FF,00,00), (00,FF,00), (00,00,FF), (00,00,00), each one cycle after its pop.
REQ-030 SHALL cover underrun: ACTIVE frame where the FIFO holds only 100 pixels -> pixels 0..99 shown, pixel 100 onward black, underrun=1, rdreq=0 until the next pixreq, then ACTIVE and underrun still 1.
REQ-031 SHALL cover reset mid-frame: reset asserted at (400,300) -> all outputs 0 asynchronously; after release, rdreq=0 until the first pixreq.
